// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter.
//   state_e : access sequencer states (IDLE -> REQ -> [RESP] -> DONE)
//   owner_e : which requester owns the access in flight
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_prio_arb.sv
// dmem_prio_arb: fixed-priority grant select (pipeline first) with a
// starvation guard that hands one grant to the debug port after STARVE_LIM
// consecutive pipeline grants made while debug was waiting.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   pipe_req_i   : pipeline request
//   dbg_req_i    : debug request
//   arb_en_i     : strobe, high in cycles where a grant is taken
//   gnt_o        : owner selected for a grant in this cycle
module dmem_prio_arb
    import dmem_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   pipe_req_i,
    input  logic   dbg_req_i,
    input  logic   arb_en_i,
    output owner_e gnt_o
);

    localparam int               CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             dbg_win;

    always_comb begin
        // Debug wins when it is alone, or when the pipeline has had its quota.
        dbg_win      = dbg_req_i & (~pipe_req_i | (starve_cnt_q == LIM));
        gnt_o        = dbg_win ? OWN_DBG : OWN_PIPE;
        starve_cnt_d = starve_cnt_q;
        if (arb_en_i & (pipe_req_i | dbg_req_i)) begin
            // Only pipeline grants taken over a waiting debug request count.
            if (dbg_win | ~dbg_req_i) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != LIM) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-RAM controller shared by the pipeline MEM
// stage and a debug/loader port. One access at a time is sequenced over the
// RAM req/ready/rvalid handshake; the pipeline is stalled until its access
// reaches DONE.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   mem_req/wen/addr/wdata             : pipeline access request (level)
//   mem_rdata, mem_stall               : pipeline load data, pipeline freeze
//   dbg_req/wen/addr/wdata             : debug access request (level)
//   dbg_ack, dbg_rdata                 : debug completion pulse and read data
//   ram_req/wen/addr/wdata             : registered RAM request
//   ram_ready, ram_rvalid, ram_rdata   : RAM accept, read valid, read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    input  logic              dbg_req,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_req,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ready,
    input  logic              ram_rvalid,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            gnt;
    logic              arb_en;
    logic              ram_req_q;
    logic              ram_wen_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              dbg_ack_q;

    assign arb_en = (state_q == IDLE);

    dmem_prio_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .pipe_req_i (mem_req),
        .dbg_req_i  (dbg_req),
        .arb_en_i   (arb_en),
        .gnt_o      (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_PIPE;
            ram_req_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            dbg_ack_q   <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req | dbg_req) begin
                        owner_q   <= gnt;
                        ram_req_q <= 1'b1;
                        if (gnt == OWN_DBG) begin
                            ram_wen_q   <= dbg_wen;
                            ram_addr_q  <= dbg_addr;
                            ram_wdata_q <= dbg_wdata;
                        end else begin
                            ram_wen_q   <= mem_wen;
                            ram_addr_q  <= mem_addr;
                            ram_wdata_q <= mem_wdata;
                        end
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ram_ready) begin
                        ram_req_q <= 1'b0;
                        if (ram_wen_q) begin
                            state_q   <= DONE;
                            dbg_ack_q <= (owner_q == OWN_DBG);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    // rvalid is only meaningful here; stray pulses elsewhere are dropped.
                    if (ram_rvalid) begin
                        rdata_q   <= ram_rdata;
                        state_q   <= DONE;
                        dbg_ack_q <= (owner_q == OWN_DBG);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall drops only in the pipeline's own DONE cycle; a flushed request
    // (mem_req low) never stalls even though its RAM access still completes.
    assign mem_stall = mem_req & ~((state_q == DONE) & (owner_q == OWN_PIPE)) & ~reset;

    assign mem_rdata = rdata_q;
    assign dbg_rdata = rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign ram_req   = ram_req_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int LIM = 4;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } ram_e_t;

    logic          clk;
    logic          reset;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall;
    logic          dbg_req;
    logic          dbg_wen;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          ram_req;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ready;
    logic          ram_rvalid;
    logic [DW-1:0] ram_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int ram_req_cyc = 0;

    bit auto_ram   = 1'b1;
    int ready_dly  = 0;
    int rvalid_dly = 1;

    ram_e_t        ram_q[$];
    logic [DW-1:0] pipe_q[$];
    logic [DW-1:0] dbg_q[$];
    logic [DW-1:0] ram_mem [logic [AW-1:0]];

    dmem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (LIM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .dbg_req    (dbg_req),
        .dbg_wen    (dbg_wen),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .ram_req    (ram_req),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_ready  (ram_ready),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    task automatic exp_ram(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_e_t e;
        e.wen   = wen;
        e.addr  = a;
        e.wdata = d;
        ram_q.push_back(e);
    endtask

    // Caller is aligned to posedge+1; returns aligned to posedge+1.
    task automatic pipe_op(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_rd, input int exp_stall);
        int n;
        n = 0;
        pipe_q.push_back(exp_rd);
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_addr  = a;
        mem_wdata = d;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n >= 200) break;
        end
        if (n >= 200) timeout("pipe_done");
        else if (exp_stall >= 0) chk("pipe_stall_cycles", n, exp_stall);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic dbg_op(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input int exp_wait);
        int n;
        n = 0;
        dbg_q.push_back(exp_rd);
        dbg_req   = 1'b1;
        dbg_wen   = wen;
        dbg_addr  = a;
        dbg_wdata = d;
        forever begin
            @(negedge clk);
            if (dbg_ack) break;
            n++;
            if (n >= 200) break;
        end
        if (n >= 200) timeout("dbg_ack");
        else if (exp_wait >= 0) chk("dbg_wait_cycles", n, exp_wait);
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // RAM responder with a small memory model.
    initial begin
        int            w;
        int            rv_w;
        bit            busy;
        bit            rv_pend;
        logic [DW-1:0] rv_data;
        w = 0; rv_w = 0; busy = 1'b0; rv_pend = 1'b0; rv_data = '0;
        ram_ready = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!auto_ram) begin
                busy    = 1'b0;
                rv_pend = 1'b0;
            end else begin
                ram_ready  = 1'b0;
                ram_rvalid = 1'b0;
                if (rv_pend) begin
                    if (rv_w == 0) begin
                        ram_rvalid = 1'b1;
                        ram_rdata  = rv_data;
                        rv_pend    = 1'b0;
                    end else begin
                        rv_w--;
                    end
                end
                if (ram_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        w    = ready_dly;
                    end
                    if (w == 0) begin
                        ram_ready = 1'b1;
                        busy      = 1'b0;
                        if (ram_wen) begin
                            ram_mem[ram_addr] = ram_wdata;
                        end else begin
                            rv_pend = 1'b1;
                            rv_w    = rvalid_dly - 1;
                            rv_data = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : '0;
                        end
                    end else begin
                        w--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        ram_e_t e;
        logic   prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_req === 1'b1) begin
                ram_req_cyc++;
                if (ram_q.size() == 0) begin
                    timeout("ram_unexpected_req");
                end else begin
                    e = ram_q[0];
                    chk("ram_wen", 32'(ram_wen), 32'(e.wen));
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("ram_wdata", ram_wdata, e.wdata);
                    if (ram_ready) void'(ram_q.pop_front());
                end
            end
            if (!reset && mem_req && !mem_stall) begin
                if (pipe_q.size() == 0) timeout("pipe_unexpected_done");
                else chk("mem_rdata", mem_rdata, pipe_q.pop_front());
            end
            if (dbg_ack === 1'b1) begin
                chk("dbg_ack_width", 32'(prev_ack), 32'(0));
                if (dbg_q.size() == 0) timeout("dbg_unexpected_ack");
                else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
            prev_ack = dbg_ack;
        end
    end

    initial begin
        int rc0;
        reset = 1'b1;
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        dbg_req = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        ram_mem[30'h44] = 32'h12345678;

        // Reset state
        @(negedge clk);
        chk("rst_mem_stall", 32'(mem_stall), 32'(0));
        chk("rst_ram_req", 32'(ram_req), 32'(0));
        chk("rst_ram_wen", 32'(ram_wen), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        mem_req = 1'b0;

        // Pipeline store, then back-to-back load, then slow load
        @(posedge clk); #1;
        rc0 = ram_req_cyc;
        exp_ram(1'b1, 30'h10, 32'hDEADBEEF);
        pipe_op(1'b1, 30'h10, 32'hDEADBEEF, 32'h0, 2);
        chk("store_ram_req_cycles", ram_req_cyc - rc0, 1);
        exp_ram(1'b0, 30'h10, 32'h0);
        pipe_op(1'b0, 30'h10, 32'h0, 32'hDEADBEEF, 3);
        ready_dly  = 2;
        rvalid_dly = 3;
        rc0 = ram_req_cyc;
        exp_ram(1'b0, 30'h44, 32'h0);
        pipe_op(1'b0, 30'h44, 32'h0, 32'h12345678, 7);
        chk("slow_load_ram_req_cycles", ram_req_cyc - rc0, 3);
        ready_dly  = 0;
        rvalid_dly = 1;

        // Simultaneous first-cycle requests: PIPE then DBG
        do_reset();
        exp_ram(1'b1, 30'h50, 32'h11111111);
        exp_ram(1'b1, 30'h51, 32'h22222222);
        fork
            pipe_op(1'b1, 30'h50, 32'h11111111, 32'h0, 2);
            dbg_op(1'b1, 30'h51, 32'h22222222, 32'h0, 5);
        join

        // Continuous contention: PIPE x4, DBG, PIPE x4, DBG
        do_reset();
        for (int i = 0; i < 4; i++) exp_ram(1'b1, AW'(32'h100 + i), 32'hA0000000 + 32'(i));
        exp_ram(1'b1, 30'h200, 32'hD1D1D1D1);
        for (int i = 4; i < 8; i++) exp_ram(1'b1, AW'(32'h100 + i), 32'hA0000000 + 32'(i));
        exp_ram(1'b0, 30'h102, 32'h0);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    pipe_op(1'b1, AW'(32'h100 + i), 32'hA0000000 + 32'(i), 32'h0, (i == 4) ? 5 : 2);
            end
            begin
                dbg_op(1'b1, 30'h200, 32'hD1D1D1D1, 32'h0, 14);
                dbg_op(1'b0, 30'h102, 32'h0, 32'hA0000002, 15);
            end
        join

        // Reset in RESP with a late rvalid
        do_reset();
        auto_ram   = 1'b0;
        ram_ready  = 1'b0;
        ram_rvalid = 1'b0;
        exp_ram(1'b0, 30'h44, 32'h0);
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 30'h44; mem_wdata = '0;
        @(posedge clk); #1;
        ram_ready = 1'b1;
        @(posedge clk); #1;
        ram_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rstresp_stall_in_reset", 32'(mem_stall), 32'(0));
        @(posedge clk); #1;
        reset      = 1'b0;
        mem_req    = 1'b0;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'hBADBAD00;
        @(negedge clk);
        chk("rstresp_ram_req", 32'(ram_req), 32'(0));
        chk("rstresp_mem_rdata", mem_rdata, 32'h0);
        chk("rstresp_dbg_ack", 32'(dbg_ack), 32'(0));
        @(posedge clk); #1;
        ram_rvalid = 1'b0;
        @(negedge clk);
        chk("rstresp_ram_req_after", 32'(ram_req), 32'(0));
        chk("rstresp_dbg_rdata", dbg_rdata, 32'h0);
        chk("rstresp_dbg_ack_after", 32'(dbg_ack), 32'(0));
        @(posedge clk); #1;
        auto_ram = 1'b1;

        // Flush: mem_req dropped while in REQ, then a debug read
        ready_dly  = 2;
        rvalid_dly = 1;
        exp_ram(1'b1, 30'h20, 32'h0BADF00D);
        exp_ram(1'b0, 30'h20, 32'h0);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 30'h20; mem_wdata = 32'h0BADF00D;
        begin
            int n;
            n = 0;
            forever begin
                @(negedge clk);
                if (ram_req) break;
                n++;
                if (n >= 50) break;
            end
            if (n >= 50) timeout("flush_ram_req");
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        fork
            dbg_op(1'b0, 30'h20, 32'h0, 32'h0BADF00D, 8);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("flush_stall", 32'(mem_stall), 32'(0));
                end
            end
        join

        repeat (4) @(posedge clk);
        #1;
        chk("ram_q_drained", ram_q.size(), 0);
        chk("pipe_q_drained", pipe_q.size(), 0);
        chk("dbg_q_drained", dbg_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory controller between the EX/MEM pipeline register and the data RAM. Shares the RAM between the pipeline MEM stage and a debug/loader port. Sequences each access over a request/ready/rvalid RAM handshake and stalls the pipeline until the MEM-stage access completes. Pipeline has fixed priority, with a starvation guard for the debug port.

## Interface
Parameters:
- ADDR_W, 30, word-address width (addresses are already word addresses, byte address >> 2)
- DATA_W, 32, data width
- STARVE_LIM, 4, consecutive pipeline grants allowed while debug waits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- mem_req  in  1  MEM stage has a load/store (level, held while mem_stall)
- mem_wen  in  1  1 = store
- mem_addr  in  ADDR_W  word address from EX/MEM
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid in pipeline DONE cycle
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- dbg_req  in  1  debug access request (level, held until dbg_ack)
- dbg_wen  in  1  1 = write
- dbg_addr  in  ADDR_W  word address
- dbg_wdata  in  DATA_W  write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read data, valid with dbg_ack
- ram_req  out  1  registered request, held until ram_ready
- ram_wen  out  1  registered write enable
- ram_addr  out  ADDR_W  registered address
- ram_wdata  out  DATA_W  registered write data
- ram_ready  in  1  RAM accepts the request this cycle
- ram_rvalid  in  1  read data valid
- ram_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, RESP, DONE. The owner register holds PIPE or DBG.
- IDLE: arbitrate when any request is present.
  - Pipeline wins by default.
  - DBG wins if dbg_req is high and starve_cnt == STARVE_LIM.
  - On grant: latch wen, addr and wdata into ram_*, set ram_req=1, go to REQ.
- REQ: hold ram_* stable until ram_ready=1.
  - Write: on ram_ready go to DONE.
  - Read: on ram_ready go to RESP.
- RESP: wait for ram_rvalid. Capture ram_rdata into the data register, then go to DONE.
- DONE (one cycle): complete the access, then return to IDLE. No arbitration in DONE.
  - Owner PIPE: mem_stall=0 and mem_rdata = captured data.
  - Owner DBG: dbg_ack=1 and dbg_rdata = captured data.
- Starvation counter starve_cnt, width clog2(STARVE_LIM+1):
  - +1 on each PIPE grant while dbg_req=1.
  - Cleared on a DBG grant, or on a PIPE grant while dbg_req=0.
  - Saturates at STARVE_LIM.
- mem_stall = mem_req & ~(state==DONE & owner==PIPE) & ~reset. Combinational.
- Read-data register is unchanged on writes. mem_rdata and dbg_rdata both drive from it.
- Only one transaction is outstanding. ram_rvalid outside RESP is ignored.
- mem_req dropping mid-transaction (flush): the transaction still completes to RAM; the DONE cycle is still taken.
- Simultaneous requests in IDLE: exactly one grant. The loser remains pending.

## Timing
- Reset values: state IDLE, owner PIPE, starve_cnt 0, ram_req/ram_wen 0, ram_addr/ram_wdata 0, read-data register 0, dbg_ack 0, mem_stall 0.
- Reset mid-transaction: abort to IDLE next edge with ram_req=0. A late ram_rvalid after reset is ignored.
- ram_req rises the cycle after the grant cycle.
- Minimum pipeline latency, measured from the first cycle mem_req is seen in IDLE:
  - Write (ram_ready immediate): 3 cycles, i.e. 2 stall cycles, then DONE.
  - Read (ram_ready immediate, rvalid next cycle): 4 cycles, i.e. 3 stall cycles, then DONE.
- Back-to-back pipeline accesses: the new mem_req is arbitrated in the IDLE cycle after DONE.
- dbg_ack is exactly one cycle wide.

## Structure
- dmem_pkg holds:
  - state enum {IDLE, REQ, RESP, DONE}
  - owner enum {OWN_PIPE, OWN_DBG}
- Sub-module dmem_prio_arb contains the fixed-priority grant plus starve_cnt (inputs: req pair, arbitrate strobe; output: grant select).
- Top level contains the FSM, the ram_* registers and the read-data register.

## Test plan
- Pipeline store: addr 0x10, data 0xDEADBEEF, ram_ready immediate -> ram_req high cycles 1–1, mem_stall high 2 cycles, low in DONE; RAM sees wen=1, addr 0x10.
- Pipeline load with ram_ready delayed 2 cycles and rvalid 3 cycles later, ram_rdata 0x12345678 -> mem_stall held throughout; mem_rdata=0x12345678 in the DONE cycle; ram_addr stable while ram_req is high.
- Both requesting continuously, STARVE_LIM=4 -> grant order PIPE×4, DBG, PIPE×4, DBG; dbg_ack pulses once per DBG transaction.
- Simultaneous first-cycle requests with starve_cnt=0 -> PIPE granted; DBG granted after the PIPE DONE, with no intervening idle PIPE request.
- Reset asserted in RESP, then ram_rvalid arrives one cycle after reset -> next cycle IDLE with ram_req=0; rvalid ignored; read-data register stays 0; no ack or stall release.
- mem_req dropped while in REQ -> RAM still receives the write; DONE is taken; mem_stall=0 throughout the drop; next dbg_req is granted normally.
